pixel_stream_processor: RTL and testbench
=========================================

// Module: pixel_stream_processor
// PURPOSE
//  Streaming per-pixel point-operation engine; successor to the BRAM-walking processor.
//  Takes pixels over a valid/ready input stream and returns results over a valid/ready output stream.
//  Generalised in channel count, channel width and frame size; adds backpressure,
//  per-frame config latching, a 2-stage pipeline, line/frame markers and two extra modes.
//  Sits between the frame reader (DMA/BRAM walker) and the frame writer.
// PARAMETERS
//  CHANNELS      3    channels per pixel; channel 0 occupies the MSBs (R,G,B order when 3)
//  CH_WIDTH      8    bits per channel (min 4)
//  IMAGE_WIDTH   512  pixels per line
//  IMAGE_HEIGHT  512  lines per frame
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  synchronous, active-high reset
//  start       in   1                  begin frame; sampled only in IDLE
//  op_select   in   3                  operation, latched at start
//  threshold   in   CH_WIDTH           threshold level, latched at start
//  brightness  in   CH_WIDTH           signed two's-complement offset, latched at start
//  s_valid     in   1                  input pixel valid
//  s_ready     out  1                  input pixel accepted when s_valid&&s_ready
//  s_data      in   CHANNELS*CH_WIDTH  input pixel
//  m_valid     out  1                  output pixel valid
//  m_ready     in   1                  downstream accepts when m_valid&&m_ready
//  m_data      out  CHANNELS*CH_WIDTH  processed pixel
//  m_eol       out  1                  qualifies m_data: last pixel of a line
//  m_last      out  1                  qualifies m_data: last pixel of the frame
//  busy        out  1                  high in RUN and DRAIN
//  done        out  1                  one-cycle pulse when the frame fully drains
// BEHAVIOUR
//  Reset values: s_ready, m_valid, m_eol, m_last, busy and done are 0; m_data is 0. Pipeline is empty, counters are 0, state is IDLE.
//  FSM:
//   IDLE:  s_ready=0. On start, latch op_select/threshold/brightness, clear x/y counters, go to RUN.
//   RUN:   Accept pixels. When pixel IMAGE_WIDTH*IMAGE_HEIGHT-1 is accepted, go to DRAIN.
//   DRAIN: s_ready=0. When both pipeline stages are empty and the final output handshake is done,
//          pulse done for 1 cycle and return to IDLE.
//  start outside IDLE is ignored. Config-input changes outside IDLE have no effect on the current frame.
//  Pipeline: 2 stages (S1 = per-channel op/grayscale sum, S2 = clamp/threshold and output register).
//   A stage advances when the next stage is empty or is advancing.
//   s_ready = RUN && S1 can advance. Throughput 1 pixel/clk; latency 2 clk from accept to m_valid with m_ready=1.
//   While m_valid&&!m_ready, m_data/m_eol/m_last hold stable. No pixel is lost or duplicated.
//   Simultaneous accept and output handshake in the same cycle is legal.
//  m_eol/m_last travel with their pixel. x wraps at IMAGE_WIDTH-1 (eol), y at IMAGE_HEIGHT-1 (last).
//  Operations (per channel c, W=CH_WIDTH, MAX=2^W-1):
//   000 pass       out=c
//   001 invert     out=~c
//   010 threshold  out = (c > threshold) ? MAX : 0; strictly greater than
//   011 brightness sum = c + sext(brightness) in W+2 signed bits; clamp to [0,MAX]
//   100 grayscale  g = (77*c0 + 150*c1 + 29*c2) >> 8; W+10-bit accumulator; all channels = g
//   101 gray-bin   g as for 100, then threshold; all channels = (g > threshold) ? MAX : 0
//   11x            pass
//   When CHANNELS != 3, modes 100 and 101 act as pass.
//  Reset mid-frame: pipeline is flushed, in-flight pixels are dropped, no done pulse is issued. The next start begins a clean frame.
// TESTING (IMAGE_WIDTH=4, IMAGE_HEIGHT=2, CHANNELS=3, CH_WIDTH=8 unless stated)
//  1 Invert, m_ready=1, 8 pixels, first = 0x102030
//     -> first output 0xEFDFCF 2 clk after accept; m_eol on pixels 3 and 7;
//        m_last on pixel 7; done 1 clk after the last handshake.
//  2 Brightness 0x64 (+100): 0xC81000 -> 0xFF7464.
//    Brightness 0xCE (-50): 0x2040FF -> 0x000ECD.
//  3 Grayscale: 0x804020 -> 0x4F4F4F; 0xFFFFFF -> 0xFFFFFF.
//    Gray-bin, threshold 0x4F: 0x804020 -> 0x000000.
//  4 Threshold 0x80: 0x808100 -> 0x00FF00. Change threshold mid-frame to 0x00 -> no effect on the remaining pixels.
//  5 Random m_ready (50%) and random s_valid over 3 frames
//     -> output sequence equals the model, m_data stable while stalled, exactly one done per frame.
//  6 Assert rst after 3 accepted pixels -> all outputs 0 next clk, no done.
//    start during RUN is ignored. A new start then processes a full 8-pixel frame correctly.

Source files
------------

// File: rtl/pixel_stream_processor.sv
// Streaming per-pixel point-operation engine: valid/ready in, two-stage pipeline
// (op/grayscale sum, then clamp/threshold into the output register), valid/ready out.
module pixel_stream_processor #(
  parameter int CHANNELS     = 3,
  parameter int CH_WIDTH     = 8,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2:0]                   op_select,
  input  logic [CH_WIDTH-1:0]          threshold,
  input  logic [CH_WIDTH-1:0]          brightness,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [CHANNELS*CH_WIDTH-1:0] s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [CHANNELS*CH_WIDTH-1:0] m_data,
  output logic                         m_eol,
  output logic                         m_last,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = CH_WIDTH;
  localparam int DW = CHANNELS * CH_WIDTH;
  localparam int XW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int YW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam logic [W-1:0] MAX = {W{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;

  logic [2:0]    op;
  logic [W-1:0]  thr;
  logic [W-1:0]  bright;
  logic [XW-1:0] x;
  logic [YW-1:0] y;

  logic pix_eol;
  logic pix_last;
  logic accept;
  logic s1_adv;
  logic s2_adv;

  logic                       s1_valid;
  logic                       s1_eol;
  logic                       s1_last;
  logic [CHANNELS-1:0][W+1:0] s1_val;
  logic [CHANNELS-1:0][W+1:0] s1_next;
  logic [CHANNELS-1:0][W-1:0] ch;
  logic [CHANNELS-1:0][W-1:0] s2_next;
  logic [DW-1:0]              m_pack;
  logic [W+9:0]               gray_acc;
  logic [W-1:0]               gray;

  // Valid/ready: a transfer happens on a rising edge where valid && ready;
  // the producer holds data stable while valid && !ready.
  assign s2_adv   = !m_valid || m_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign s_ready  = (state == RUN) && s1_adv;
  assign accept   = s_valid && s_ready;
  assign busy     = (state != IDLE);
  assign pix_eol  = (x == XW'(IMAGE_WIDTH - 1));
  assign pix_last = pix_eol && (y == YW'(IMAGE_HEIGHT - 1));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign ch[c] = s_data[(CHANNELS-1-c)*W +: W];
  end

  if (CHANNELS == 3) begin : g_gray
    assign gray_acc = (W+10)'(ch[0]) * (W+10)'(77)
                    + (W+10)'(ch[1]) * (W+10)'(150)
                    + (W+10)'(ch[2]) * (W+10)'(29);
  end else begin : g_no_gray
    assign gray_acc = '0;
  end

  assign gray = W'(gray_acc >> 8);

  // Stage 1: brightness is kept as a W+2 bit signed sum so stage 2 can clamp it.
  always_comb begin
    s1_next = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (op)
        3'd1:       s1_next[c] = {2'b00, ~ch[c]};
        3'd3:       s1_next[c] = {2'b00, ch[c]} + {{2{bright[W-1]}}, bright};
        3'd4, 3'd5: s1_next[c] = {2'b00, gray};
        default:    s1_next[c] = {2'b00, ch[c]};
      endcase
    end
  end

  always_comb begin
    s2_next = '0;
    m_pack  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (op)
        3'd2, 3'd5: s2_next[c] = (s1_val[c][W-1:0] > thr) ? MAX : '0;
        3'd3: begin
          if (s1_val[c][W+1])  s2_next[c] = '0;
          else if (s1_val[c][W]) s2_next[c] = MAX;
          else                   s2_next[c] = s1_val[c][W-1:0];
        end
        default:    s2_next[c] = s1_val[c][W-1:0];
      endcase
      m_pack[(CHANNELS-1-c)*W +: W] = s2_next[c];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      op       <= 3'd0;
      thr      <= '0;
      bright   <= '0;
      x        <= '0;
      y        <= '0;
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_last  <= 1'b0;
      s1_val   <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_eol    <= 1'b0;
      m_last   <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Grayscale modes need exactly three channels; otherwise they pass through.
            op     <= ((op_select == 3'd4 || op_select == 3'd5) && CHANNELS != 3) ? 3'd0 : op_select;
            thr    <= threshold;
            bright <= brightness;
            x      <= '0;
            y      <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            x <= pix_eol ? '0 : x + 1'b1;
            if (pix_eol) y <= pix_last ? '0 : y + 1'b1;
            if (pix_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (!s1_valid && s2_adv) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_val  <= s1_next;
          s1_eol  <= pix_eol;
          s1_last <= pix_last;
        end
      end

      if (s2_adv) begin
        m_valid <= s1_valid;
        if (s1_valid) begin
          m_data <= m_pack;
          m_eol  <= s1_eol;
          m_last <= s1_last;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_processor.sv
// Bench for pixel_stream_processor on a 4x2 RGB888 frame: directed frames,
// an arithmetic reference model feeding an expected queue, and literal pins.
module tb_pixel_stream_processor;

  localparam int IW   = 4;
  localparam int IH   = 2;
  localparam int NPIX = IW * IH;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op_select;
  logic [7:0]  threshold;
  logic [7:0]  brightness;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [23:0] m_data;
  logic        m_eol;
  logic        m_last;
  logic        busy;
  logic        done;

  pixel_stream_processor #(
    .CHANNELS(3), .CH_WIDTH(8), .IMAGE_WIDTH(IW), .IMAGE_HEIGHT(IH)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .op_select(op_select),
    .threshold(threshold), .brightness(brightness),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_eol(m_eol), .m_last(m_last), .busy(busy), .done(done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int pix_idx   = 0;
  int acc0_cyc, out0_cyc, last_hs_cyc, done_cyc;
  bit seen_valid = 0;
  bit rdy_rand   = 0;
  bit prev_stall = 0;
  logic [25:0] prev_out;

  logic [2:0] cfg_op;
  logic [7:0] cfg_thr;
  logic [7:0] cfg_br;

  logic [25:0] exp_q[$];
  logic [25:0] out_log[$];

  logic [23:0] tbl [6] = '{24'h00FF7F, 24'h123456, 24'hFEDCBA, 24'h7F8081, 24'h010203, 24'hA5A5A5};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Reference model: plain integer arithmetic on the three channels.
  function automatic logic [23:0] model(input logic [2:0] op, input logic [7:0] thr,
                                        input logic [7:0] br, input logic [23:0] d);
    int c[3];
    int r[3];
    int g, b, t;
    c[0] = int'(d[23:16]);
    c[1] = int'(d[15:8]);
    c[2] = int'(d[7:0]);
    b = int'($signed(br));
    t = int'(thr);
    g = (77 * c[0] + 150 * c[1] + 29 * c[2]) / 256;
    for (int i = 0; i < 3; i++) begin
      case (op)
        3'd1: r[i] = 255 - c[i];
        3'd2: r[i] = (c[i] > t) ? 255 : 0;
        3'd3: begin
          r[i] = c[i] + b;
          if (r[i] < 0)   r[i] = 0;
          if (r[i] > 255) r[i] = 255;
        end
        3'd4: r[i] = g;
        3'd5: r[i] = (g > t) ? 255 : 0;
        default: r[i] = c[i];
      endcase
    end
    return {8'(r[0]), 8'(r[1]), 8'(r[2])};
  endfunction

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [25:0] e;
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        check("stall_hold", {5'd0, m_valid, m_eol, m_last, m_data}, {5'd0, 1'b1, prev_out});
      if (m_valid && !seen_valid) begin
        seen_valid = 1;
        out0_cyc   = cyc;
      end
      if (m_valid && m_ready) begin
        check("output_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pixel_out", {6'd0, m_eol, m_last, m_data}, {6'd0, e});
        end
        out_log.push_back({m_eol, m_last, m_data});
        last_hs_cyc = cyc;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back({(pix_idx % IW) == IW - 1, pix_idx == NPIX - 1,
                         model(cfg_op, cfg_thr, cfg_br, s_data)});
        if (pix_idx == 0) acc0_cyc = cyc;
        pix_idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("drained_at_done", 32'(exp_q.size()), 32'd0);
      end
      prev_stall = m_valid && !m_ready;
      prev_out   = {m_eol, m_last, m_data};
    end
  end

  always @(posedge clk) begin
    #1;
    m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- driver tasks ----------------
  task automatic start_frame(input logic [2:0] op, input logic [7:0] thr, input logic [7:0] br);
    cfg_op  = op;
    cfg_thr = thr;
    cfg_br  = br;
    pix_idx = 0;
    seen_valid = 0;
    out_log.delete();
    op_select  = op;
    threshold  = thr;
    brightness = br;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pixel(input logic [23:0] d, input bit rnd);
    logic hs;
    int n;
    if (rnd) begin
      s_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    s_valid = 1'b1;
    s_data  = d;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 100) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk); #1;
      n++;
    end
    s_valid = 1'b0;
    check("send_accepted", {31'd0, hs}, 32'd1);
  endtask

  task automatic wait_done(input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    #1;
    check("one_done_per_frame", 32'(done_cnt - d0), 32'd1);
  endtask

  // Perturb: mid-frame config changes and a start pulse that must all be ignored.
  task automatic run_frame(input logic [2:0] op, input logic [7:0] thr, input logic [7:0] br,
                           input logic [23:0] p0, input logic [23:0] p1,
                           input bit rnd, input bit perturb);
    int d0;
    logic [23:0] px;
    d0 = done_cnt;
    start_frame(op, thr, br);
    for (int i = 0; i < NPIX; i++) begin
      px = (i == 0) ? p0 : (i == 1) ? p1 : tbl[i-2];
      if (perturb && i == 2) begin
        threshold  = 8'h00;
        brightness = 8'h7F;
        op_select  = 3'd0;
        start      = 1'b1;
      end
      send_pixel(px, rnd);
      if (perturb && i == 2) start = 1'b0;
    end
    wait_done(d0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] eolv, lastv;
    int d0;
    rst = 1'b1; start = 1'b0; op_select = 3'd0; threshold = 8'h00; brightness = 8'h00;
    s_valid = 1'b0; s_data = 24'h0; m_ready = 1'b1;
    cfg_op = 3'd0; cfg_thr = 8'h00; cfg_br = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {2'd0, s_ready, m_valid, m_eol, m_last, busy, done, m_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Invert, full throughput: latency, markers and done timing.
    run_frame(3'd1, 8'h00, 8'h00, 24'h102030, 24'h405060, 0, 0);
    check("invert_first", {8'd0, out_log[0][23:0]}, 32'h00EFDFCF);
    check("invert_count", 32'(out_log.size()), 32'd8);
    eolv = '0; lastv = '0;
    for (int i = 0; i < 8 && i < out_log.size(); i++) begin
      eolv[i]  = out_log[i][25];
      lastv[i] = out_log[i][24];
    end
    check("eol_pattern", {24'd0, eolv}, 32'h88);
    check("last_pattern", {24'd0, lastv}, 32'h80);
    check("latency_2clk", 32'(out0_cyc - acc0_cyc), 32'd2);
    check("done_after_last", 32'(done_cyc - last_hs_cyc), 32'd1);

    // Brightness +100 and -50 with clamping.
    run_frame(3'd3, 8'h00, 8'h64, 24'hC81000, 24'h000000, 0, 0);
    check("bright_pos", {8'd0, out_log[0][23:0]}, 32'h00FF7464);
    run_frame(3'd3, 8'h00, 8'hCE, 24'h2040FF, 24'h000000, 0, 0);
    check("bright_neg", {8'd0, out_log[0][23:0]}, 32'h00000ECD);

    // Grayscale and gray-bin.
    run_frame(3'd4, 8'h00, 8'h00, 24'h804020, 24'hFFFFFF, 0, 0);
    check("gray_mid", {8'd0, out_log[0][23:0]}, 32'h004F4F4F);
    check("gray_full", {8'd0, out_log[1][23:0]}, 32'h00FFFFFF);
    run_frame(3'd5, 8'h4F, 8'h00, 24'h804020, 24'hFFFFFF, 0, 0);
    check("graybin_eq", {8'd0, out_log[0][23:0]}, 32'h00000000);
    check("graybin_hi", {8'd0, out_log[1][23:0]}, 32'h00FFFFFF);

    // Threshold, with mid-frame config changes and a stray start.
    run_frame(3'd2, 8'h80, 8'h00, 24'h808100, 24'h7F8081, 0, 1);
    check("thresh_first", {8'd0, out_log[0][23:0]}, 32'h0000FF00);
    check("thresh_after_change", {8'd0, out_log[6][23:0]}, 32'h00000000);

    // Random backpressure and random input gaps.
    rdy_rand = 1;
    run_frame(3'd0, 8'h00, 8'h00, 24'($urandom), 24'($urandom), 1, 0);
    run_frame(3'd6, 8'h00, 8'h00, 24'($urandom), 24'($urandom), 1, 0);
    run_frame(3'd5, 8'h40, 8'h00, 24'($urandom), 24'($urandom), 1, 1);
    rdy_rand = 0;
    @(posedge clk); #1;

    // Reset mid-frame after three accepted pixels.
    d0 = done_cnt;
    start_frame(3'd1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) send_pixel(tbl[i], 0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("reset_midframe", {2'd0, s_ready, m_valid, m_eol, m_last, busy, done, m_data}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pix_idx = 0;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_cnt - d0), 32'd0);

    // Clean frame after reset, with a start pulse during RUN.
    run_frame(3'd1, 8'h00, 8'h00, 24'h102030, 24'hFFFFFF, 0, 1);
    check("post_reset_first", {8'd0, out_log[0][23:0]}, 32'h00EFDFCF);
    check("post_reset_count", 32'(out_log.size()), 32'd8);

    check("total_done", 32'(done_cnt), 32'd10);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
